// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-cache miss/refill engine and its write buffer.
package mem_if_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT
  } refill_state_t;

  // One buffered write-through store: word address and data.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Small synchronous FIFO holding write-through stores until the memory port is free.
module write_buffer_fifo
  import mem_if_pkg::*;
#(
  parameter int WB_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_push,
  input  wb_entry_t                       i_entry,
  input  logic                            i_pop,
  output wb_entry_t                       o_head,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(WB_DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  wb_entry_t          r_mem [WB_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Overflow/underflow protection lives here so callers can drive push/pop freely.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage array: written on push, read at the head pointer.
  // NOTE: the data array has no reset; validity is tracked by r_count, so resetting it would only add flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers wrap naturally because WB_DEPTH is a power of two; occupancy tracked separately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(WB_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/line_refill_ctrl.sv
// Miss/refill engine: drains buffered stores, then fetches a cache line word by word
// and streams each returned word straight to the cache.
module line_refill_ctrl
  import mem_if_pkg::*;
#(
  parameter int BLOCK_WORDS = mem_if_pkg::BLOCK_WORDS,
  parameter int WB_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [27:0] miss_addr,
  output logic        miss_ready,
  input  logic        wr_req,
  input  logic [29:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        fill_valid,
  output logic [1:0]  fill_idx,
  output logic [31:0] fill_data,
  output logic        fill_done,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int FCNT_W = $clog2(WB_DEPTH + 1);
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(BLOCK_WORDS - 1);

  refill_state_t        r_state;
  logic [27:0]          r_line;
  logic [OFFSET_W-1:0]  r_cnt;

  wb_entry_t            w_push_entry;
  wb_entry_t            w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [FCNT_W-1:0]    w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_miss_acc;

  assign miss_ready   = (r_state == IDLE);
  assign wr_ready     = !w_full;
  assign w_miss_acc   = miss_req && miss_ready;
  assign w_push       = wr_req && wr_ready;
  assign w_push_entry = '{addr: wr_addr, data: wr_data};
  assign w_pop        = mem_req && mem_we && mem_gnt;
  assign busy         = (r_state != IDLE) || !w_empty;

  write_buffer_fifo #(
    .WB_DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_entry  (w_push_entry),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Refill sequencer: line latch, word counter and state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss_acc) begin
            r_line <= miss_addr;
            r_cnt  <= '0;
            // A store pushed in the accept cycle must also reach memory before the reads.
            r_state <= (!w_empty || w_push) ? DRAIN : RD_REQ;
          end
        end
        DRAIN: begin
          // Leave only when the final entry is granted and nothing new arrived behind it.
          if (w_pop && (w_count == FCNT_W'(1)) && !w_push) begin
            r_state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (mem_gnt) r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            if (r_cnt == LAST_WORD) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_cnt + OFFSET_W'(1);
              r_state <= RD_REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-port mux: buffered writes in IDLE/DRAIN, line reads in RD_REQ.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !w_miss_acc) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = w_head.addr;
          mem_wdata = w_head.data;
        end
      end
      DRAIN: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_head.addr;
        mem_wdata = w_head.data;
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_line, r_cnt};
      end
      default: ;
    endcase
  end

  // Fill stream: returned read data is forwarded in the same cycle it arrives.
  always_comb begin
    fill_valid = (r_state == RD_WAIT) && mem_rvalid;
    fill_idx   = fill_valid ? r_cnt : '0;
    fill_data  = fill_valid ? mem_rdata : '0;
    fill_done  = fill_valid && (r_cnt == LAST_WORD);
  end

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed self-checking bench for line_refill_ctrl with a simple in-order memory model.
module tb_line_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_req;
  logic [27:0] miss_addr;
  logic        miss_ready;
  logic        wr_req;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        fill_valid;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        gnt_en;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stray_rvalid;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } fill_t;

  txn_t        log_q[$];
  fill_t       fill_q[$];
  logic [31:0] mem_store [logic [29:0]];
  int          cyc;
  int          acc_cyc;
  int          n_checks;
  int          n_fail;

  assign mem_gnt    = gnt_en;
  assign mem_rvalid = m_rvalid | stray_rvalid;
  assign mem_rdata  = stray_rvalid ? 32'hBAD0_BAD0 : m_rdata;

  line_refill_ctrl #(
    .BLOCK_WORDS (4),
    .WB_DEPTH    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fill_valid (fill_valid),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .fill_done  (fill_done),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return 32'hA000_0000 | {2'b00, a};
  endfunction

  // Memory model: one-cycle read return, logs every granted transaction, records fills.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    m_rvalid <= 1'b0;
    if (mem_req && mem_gnt) begin
      log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
      if (mem_we) begin
        mem_store[mem_addr] = mem_wdata;
      end else begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : dflt(mem_addr);
      end
    end
    if (fill_valid) fill_q.push_back('{idx: fill_idx, data: fill_data, done: fill_done, cyc: cyc});
    if (miss_req && miss_ready) acc_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fills(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fill_q.size() >= n) break;
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    gnt_en = 1'b1; stray_rvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_miss_ready", miss_ready, 1);
    check("rst_wr_ready",   wr_ready,   1);
    check("rst_busy",       busy,       0);
    check("rst_mem_req",    mem_req,    0);
    check("rst_fill_valid", fill_valid, 0);
    check("rst_fill_idx",   fill_idx,   0);
    check("rst_fill_data",  fill_data,  0);

    // T1: plain refill, zero-wait memory
    log_q.delete(); fill_q.delete();
    miss_req = 1'b1; miss_addr = 28'h000_0123;
    tick();
    miss_req = 1'b0;
    check("t1_rdreq_req",   mem_req,    1);
    check("t1_rdreq_we",    mem_we,     0);
    check("t1_rdreq_addr",  mem_addr,   30'h48C);
    check("t1_miss_ready0", miss_ready, 0);
    check("t1_busy",        busy,       1);
    wait_fills(4, 20);
    check("t1_fill_count", fill_q.size(), 4);
    check("t1_log_count",  log_q.size(),  4);
    for (int i = 0; i < 4; i++) begin
      if (i < fill_q.size()) begin
        check($sformatf("t1_idx%0d", i),  fill_q[i].idx,  i);
        check($sformatf("t1_data%0d", i), fill_q[i].data, 32'hA000_048C + i);
        check($sformatf("t1_done%0d", i), fill_q[i].done, (i == 3));
      end
      if (i < log_q.size()) begin
        check($sformatf("t1_rd_we%0d", i),   log_q[i].we,   0);
        check($sformatf("t1_rd_addr%0d", i), log_q[i].addr, 30'h48C + i);
      end
    end
    if (fill_q.size() == 4) check("t1_latency", fill_q[3].cyc - acc_cyc, 8);
    check("t1_miss_ready1", miss_ready, 1);
    check("t1_busy_after",  busy,       0);

    // T2: write to the line, then miss on it the next cycle
    log_q.delete(); fill_q.delete();
    wr_req = 1'b1; wr_addr = 30'h48D; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_req = 1'b0; miss_req = 1'b1; miss_addr = 28'h000_0123;
    #1;
    check("t2_accept_ready", miss_ready, 1);
    check("t2_accept_nopop", mem_req,    0);
    tick();
    miss_req = 1'b0;
    check("t2_drain_we",   mem_we,   1);
    check("t2_drain_addr", mem_addr, 30'h48D);
    wait_fills(4, 20);
    check("t2_log_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      check("t2_first_we",   log_q[0].we,   1);
      check("t2_first_addr", log_q[0].addr, 30'h48D);
      check("t2_first_data", log_q[0].data, 32'hDEAD_BEEF);
      check("t2_second_we",  log_q[1].we,   0);
    end
    check("t2_fill_count", fill_q.size(), 4);
    if (fill_q.size() == 4) begin
      check("t2_idx1_data", fill_q[1].data, 32'hDEAD_BEEF);
      check("t2_idx0_data", fill_q[0].data, 32'hA000_048C);
    end

    // T3: fill the write buffer while memory refuses grants
    log_q.delete();
    gnt_en = 1'b0;
    wr_req = 1'b1; wr_addr = 30'h100; wr_data = 32'h11;
    #1 check("t3_ready_0", wr_ready, 1);
    tick();
    wr_addr = 30'h101; wr_data = 32'h22;
    #1 check("t3_ready_1", wr_ready, 1);
    tick();
    wr_addr = 30'h102; wr_data = 32'h33;
    #1;
    check("t3_full",      wr_ready,  0);
    check("t3_busy",      busy,      1);
    check("t3_head_req",  mem_req,   1);
    check("t3_head_we",   mem_we,    1);
    check("t3_head_addr", mem_addr,  30'h100);
    check("t3_head_data", mem_wdata, 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_hold_ready%0d", i), wr_ready, 0);
      check($sformatf("t3_hold_addr%0d", i),  mem_addr, 30'h100);
    end
    gnt_en = 1'b1;
    tick();
    check("t3_ready_after_pop", wr_ready, 1);
    tick();
    wr_req = 1'b0;
    wait_idle(10);
    check("t3_idle",      busy,         0);
    check("t3_log_count", log_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_q.size()) begin
        check($sformatf("t3_wr_we%0d", i),   log_q[i].we,   1);
        check($sformatf("t3_wr_addr%0d", i), log_q[i].addr, 30'h100 + i);
        check($sformatf("t3_wr_data%0d", i), log_q[i].data, 32'h11 * (i + 1));
      end
    end

    // T4: grant withheld for 5 cycles in RD_REQ
    log_q.delete(); fill_q.delete();
    gnt_en = 1'b0;
    miss_req = 1'b1; miss_addr = 28'h000_0200;
    tick();
    miss_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_req%0d", i),   mem_req,    1);
      check($sformatf("t4_we%0d", i),    mem_we,     0);
      check($sformatf("t4_addr%0d", i),  mem_addr,   30'h800);
      check($sformatf("t4_fill%0d", i),  fill_valid, 0);
      tick();
    end
    check("t4_no_txn", log_q.size(), 0);
    gnt_en = 1'b1;
    wait_fills(4, 20);
    check("t4_fill_count", fill_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < fill_q.size()) begin
        check($sformatf("t4_data%0d", i), fill_q[i].data, 32'hA000_0800 + i);
        check($sformatf("t4_done%0d", i), fill_q[i].done, (i == 3));
      end
    end
    check("t4_miss_ready", miss_ready, 1);

    // T5: reset in RD_WAIT after two words, then a stray read return
    fill_q.delete();
    miss_req = 1'b1; miss_addr = 28'h000_0300;
    tick();
    miss_req = 1'b0;
    wait_fills(2, 10);
    check("t5_two_words", fill_q.size(), 2);
    tick();
    check("t5_in_rd_wait", fill_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill_q.delete(); log_q.delete();
    stray_rvalid = 1'b1;
    #1;
    check("t5_stray_fill", fill_valid, 0);
    check("t5_miss_ready", miss_ready, 1);
    check("t5_busy",       busy,       0);
    tick();
    stray_rvalid = 1'b0;
    tick();
    check("t5_no_fills", fill_q.size(), 0);
    check("t5_no_txn",   log_q.size(),  0);
    check("t5_mem_req",  mem_req,       0);

    // T6: store arrives mid-refill, drains only after the line is done
    log_q.delete(); fill_q.delete();
    miss_req = 1'b1; miss_addr = 28'h000_0400;
    tick();
    miss_req = 1'b0;
    tick();
    check("t6_rd_wait_fill", fill_valid, 1);
    wr_req = 1'b1; wr_addr = 30'h555; wr_data = 32'hCAFE_F00D;
    #1;
    check("t6_wr_ready",   wr_ready, 1);
    check("t6_no_wr_issue", mem_req, 0);
    tick();
    wr_req = 1'b0;
    check("t6_busy", busy, 1);
    wait_fills(4, 20);
    wait_idle(10);
    check("t6_idle",      busy,         0);
    check("t6_log_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t6_rd_we%0d", i),   log_q[i].we,   0);
        check($sformatf("t6_rd_addr%0d", i), log_q[i].addr, 30'h1000 + i);
      end
      check("t6_wr_we",   log_q[4].we,   1);
      check("t6_wr_addr", log_q[4].addr, 30'h555);
      check("t6_wr_data", log_q[4].data, 32'hCAFE_F00D);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
